// File: rtl/sram_pkg.sv
// Shared constants, error-source encoding and address-range helper for the
// banked on-chip SRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_BANK_BYTES = 2048;
  localparam int unsigned SRAM_MACRO_AW   = 9;
  localparam int unsigned SRAM_DW         = 32;

  typedef enum logic {
    ERR_DPORT = 1'b0,
    ERR_IPORT = 1'b1
  } obi_err_src_e;

  // Subtract-then-compare so that base + size may sit at the top of the map.
  function automatic logic sram_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/sram_banked_ctrl_bank.sv
// sram_bank: one 2 kB bank with the pin behaviour of the sky130 1rw1r 32x512
// macro (DELAY 0): writes and reads are sampled on the rising edge, read data
// appears after that edge and holds until the next read on the same port.
// Enables are active-high here and mapped onto the macro's active-low csb/web.
// Ports:
//   clk_i                  clock
//   rw_en_i / rw_we_i      rw port enable / write enable
//   rw_be_i                byte write mask
//   rw_addr_i, rw_wdata_i  rw port word address / write data
//   rw_rdata_o             rw port read data
//   r_en_i, r_addr_i       read-only port enable / word address
//   r_rdata_o              read-only port read data
module sram_bank
  import sram_pkg::*;
#(
  parameter int unsigned AW = SRAM_MACRO_AW
) (
  input  logic               clk_i,
  input  logic               rw_en_i,
  input  logic               rw_we_i,
  input  logic [3:0]         rw_be_i,
  input  logic [AW-1:0]      rw_addr_i,
  input  logic [SRAM_DW-1:0] rw_wdata_i,
  output logic [SRAM_DW-1:0] rw_rdata_o,
  input  logic               r_en_i,
  input  logic [AW-1:0]      r_addr_i,
  output logic [SRAM_DW-1:0] r_rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [SRAM_DW-1:0] mem_q [DEPTH];
  logic [SRAM_DW-1:0] rw_rdata_q, r_rdata_q;
  logic               csb0_c, web0_c, csb1_c;
  logic [SRAM_DW-1:0] bit_mask_c;

  assign csb0_c     = ~rw_en_i;
  assign web0_c     = ~rw_we_i;
  assign csb1_c     = ~r_en_i;
  assign bit_mask_c = {{8{rw_be_i[3]}}, {8{rw_be_i[2]}}, {8{rw_be_i[1]}}, {8{rw_be_i[0]}}};

  // Array storage and read registers; no reset on the macro contents.
  always_ff @(posedge clk_i) begin
    if (!csb0_c && !web0_c) begin
      mem_q[rw_addr_i] <= (mem_q[rw_addr_i] & ~bit_mask_c) | (rw_wdata_i & bit_mask_c);
    end
    if (!csb0_c && web0_c) begin
      rw_rdata_q <= mem_q[rw_addr_i];
    end
    if (!csb1_c) begin
      r_rdata_q <= mem_q[r_addr_i];
    end
  end

  assign rw_rdata_o = rw_rdata_q;
  assign r_rdata_o  = r_rdata_q;

endmodule

// File: rtl/sram_banked_ctrl.sv
// sram_banked_ctrl: dual-port OBI controller for the banked on-chip SRAM.
// Data port gets the rw port of every bank, instruction port the r port.
// Out-of-range accesses and instruction writes are granted, touch no bank and
// return err=1 / rdata=0; the first such error is captured in sticky status.
// Optional feature macro: SRAM_COLLISION_ARB_EN -- arbitrates same-word
// data-write / instruction-read collisions with a starvation guard.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   d_req_i/d_gnt_o/d_addr_i/d_we_i/d_be_i/d_wdata_i   data request channel
//   d_rvalid_o/d_rdata_o/d_err_o     data response channel
//   i_req_i/i_gnt_o/i_addr_i/i_we_i  instruction request channel
//   i_rvalid_o/i_rdata_o/i_err_o     instruction response channel
//   illegal_memory_o                 pulse with any error response
//   err_valid_o/err_addr_o/err_port_o  sticky first-error capture
module sram_banked_ctrl
  import sram_pkg::*;
#(
  parameter logic [31:0]  BASE_ADDR = 32'h8000_0000,
  parameter int unsigned  NUM_BANKS = 8,
  parameter int unsigned  BANK_AW   = 9,
  parameter int unsigned  MAX_STALL = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  output logic        d_gnt_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  input  logic        i_req_i,
  output logic        i_gnt_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_we_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  output logic        illegal_memory_o,
  output logic        err_valid_o,
  output logic [31:0] err_addr_o,
  output logic        err_port_o
);

  localparam int unsigned BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [31:0] REGION_BYTES = 32'(NUM_BANKS * SRAM_BANK_BYTES);

  logic               d_in_range_c, i_in_range_c, d_err_c, i_err_c;
  logic               d_err_fire_c, i_err_fire_c;
  logic [BANK_W-1:0]  d_bank_c, i_bank_c;
  logic [BANK_AW-1:0] d_word_c, i_word_c;
  logic [NUM_BANKS-1:0] d_en_c, i_en_c, d_sel_q, i_sel_q;
  logic [SRAM_DW-1:0] d_bank_rdata [NUM_BANKS];
  logic [SRAM_DW-1:0] i_bank_rdata [NUM_BANKS];
  logic               d_rvalid_q, d_err_q, i_rvalid_q, i_err_q, illegal_q;
  logic               err_valid_q;
  logic [31:0]        err_addr_q;
  obi_err_src_e       err_port_q;

  // Address decode.
  assign d_in_range_c = sram_in_range(d_addr_i, BASE_ADDR, REGION_BYTES);
  assign i_in_range_c = sram_in_range(i_addr_i, BASE_ADDR, REGION_BYTES);
  assign d_bank_c     = (NUM_BANKS > 1) ? d_addr_i[BANK_AW+2 +: BANK_W] : '0;
  assign i_bank_c     = (NUM_BANKS > 1) ? i_addr_i[BANK_AW+2 +: BANK_W] : '0;
  assign d_word_c     = d_addr_i[BANK_AW+1:2];
  assign i_word_c     = i_addr_i[BANK_AW+1:2];
  assign d_err_c      = ~d_in_range_c;
  assign i_err_c      = ~i_in_range_c | i_we_i;

`ifdef SRAM_COLLISION_ARB_EN
  logic       collision_c, i_wins_c;
  logic [3:0] stall_q;

  // Both legal and in range, so equal word addresses imply same bank and word.
  assign collision_c = d_req_i & d_we_i & d_in_range_c & i_req_i & ~i_we_i & i_in_range_c
                     & (d_addr_i[31:2] == i_addr_i[31:2]);
  assign i_wins_c    = (stall_q == 4'(MAX_STALL));
  assign d_gnt_o     = d_req_i & ~(collision_c & i_wins_c);
  assign i_gnt_o     = i_req_i & ~(collision_c & ~i_wins_c);

  // Consecutive instruction stalls; any instruction grant clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (i_gnt_o) begin
      stall_q <= '0;
    end else if (collision_c) begin
      stall_q <= stall_q + 4'd1;
    end
  end
`else
  logic [3:0] unused_max_stall;

  assign unused_max_stall = 4'(MAX_STALL);
  assign d_gnt_o          = d_req_i;
  assign i_gnt_o          = i_req_i;
`endif

  assign d_err_fire_c = d_gnt_o & d_err_c;
  assign i_err_fire_c = i_gnt_o & i_err_c;

  // Per-bank enables, forced off during reset.
  always_comb begin
    d_en_c = '0;
    i_en_c = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      d_en_c[b] = ~rst_i & d_gnt_o & d_in_range_c & (d_bank_c == BANK_W'(b));
      i_en_c[b] = ~rst_i & i_gnt_o & i_in_range_c & ~i_we_i & (i_bank_c == BANK_W'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sram_bank #(.AW(BANK_AW)) u_bank (
      .clk_i      (clk_i),
      .rw_en_i    (d_en_c[b]),
      .rw_we_i    (d_we_i),
      .rw_be_i    (d_be_i),
      .rw_addr_i  (d_word_c),
      .rw_wdata_i (d_wdata_i),
      .rw_rdata_o (d_bank_rdata[b]),
      .r_en_i     (i_en_c[b]),
      .r_addr_i   (i_word_c),
      .r_rdata_o  (i_bank_rdata[b])
    );
  end

  // Response tracking and sticky first-error capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_sel_q     <= '0;
      i_rvalid_q  <= 1'b0;
      i_err_q     <= 1'b0;
      i_sel_q     <= '0;
      illegal_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_port_q  <= ERR_DPORT;
    end else begin
      d_rvalid_q <= d_gnt_o;
      d_err_q    <= d_err_fire_c;
      d_sel_q    <= d_we_i ? '0 : d_en_c;
      i_rvalid_q <= i_gnt_o;
      i_err_q    <= i_err_fire_c;
      i_sel_q    <= i_en_c;
      illegal_q  <= d_err_fire_c | i_err_fire_c;
      if (!err_valid_q && (d_err_fire_c || i_err_fire_c)) begin
        err_valid_q <= 1'b1;
        err_addr_q  <= d_err_fire_c ? d_addr_i : i_addr_i;
        err_port_q  <= d_err_fire_c ? ERR_DPORT : ERR_IPORT;
      end
    end
  end

  // Select vectors are zero for errors, writes and idle cycles, so rdata is 0 then.
  always_comb begin
    d_rdata_o = '0;
    i_rdata_o = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (d_sel_q[b]) d_rdata_o = d_rdata_o | d_bank_rdata[b];
      if (i_sel_q[b]) i_rdata_o = i_rdata_o | i_bank_rdata[b];
    end
  end

  assign d_rvalid_o       = d_rvalid_q;
  assign d_err_o          = d_err_q;
  assign i_rvalid_o       = i_rvalid_q;
  assign i_err_o          = i_err_q;
  assign illegal_memory_o = illegal_q;
  assign err_valid_o      = err_valid_q;
  assign err_addr_o       = err_addr_q;
  assign err_port_o       = err_port_q;

endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Self-checking bench for sram_banked_ctrl: directed scenarios followed by
// randomized traffic, compared against a word-level memory/status model.
module tb_sram_banked_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned NB   = 8;
  localparam int unsigned MS   = 4;
  localparam longint unsigned REGION = 64'(NB) * 64'd2048;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        d_req_i, d_we_i, i_req_i, i_we_i;
  logic [31:0] d_addr_i, d_wdata_i, i_addr_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o, i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] d_rdata_o, i_rdata_o, err_addr_o;
  logic        illegal_memory_o, err_valid_o, err_port_o;

  always #5 clk_i = ~clk_i;

  sram_banked_ctrl #(
    .BASE_ADDR(BASE), .NUM_BANKS(NB), .BANK_AW(9), .MAX_STALL(MS)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_gnt_o(d_gnt_o), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
    .d_be_i(d_be_i), .d_wdata_i(d_wdata_i), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .i_req_i(i_req_i), .i_gnt_o(i_gnt_o), .i_addr_i(i_addr_i), .i_we_i(i_we_i),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .illegal_memory_o(illegal_memory_o), .err_valid_o(err_valid_o),
    .err_addr_o(err_addr_o), .err_port_o(err_port_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: word-indexed memory, stall count, error capture.
  logic [31:0] mem_m [int];
  int          stall_m = 0;
  bit          cap_v = 0, cap_port = 0;
  logic [31:0] cap_addr = '0;
  bit          e_d_rv = 0, e_d_err = 0, e_d_known = 1, e_i_rv = 0, e_i_err = 0, e_i_known = 1, e_ill = 0;
  logic [31:0] e_d_rd = '0, e_i_rd = '0;
  bit          last_dg, last_ig;

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned x = 64'(a);
    return (x >= 64'(BASE)) && (x < 64'(BASE) + REGION);
  endfunction

  function automatic int wkey(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Called at a negedge: check the previous cycle's response, apply one request,
  // check the grants, advance the model, and return at the next negedge.
  task automatic drive(input bit rst, input bit dreq, input logic [31:0] daddr, input bit dwe,
                       input logic [3:0] dbe, input logic [31:0] dwd,
                       input bit ireq, input logic [31:0] iaddr, input bit iwe);
    bit d_in, i_in, same, coll, dg, ig;
    logic [31:0] mask, old;
    chk("d_rvalid", 32'(d_rvalid_o), 32'(e_d_rv));
    chk("d_err", 32'(d_err_o), 32'(e_d_err));
    if (e_d_known) chk("d_rdata", d_rdata_o, e_d_rd);
    chk("i_rvalid", 32'(i_rvalid_o), 32'(e_i_rv));
    chk("i_err", 32'(i_err_o), 32'(e_i_err));
    if (e_i_known) chk("i_rdata", i_rdata_o, e_i_rd);
    chk("illegal", 32'(illegal_memory_o), 32'(e_ill));
    chk("err_valid", 32'(err_valid_o), 32'(cap_v));
    chk("err_addr", err_addr_o, cap_addr);
    chk("err_port", 32'(err_port_o), 32'(cap_port));

    rst_i = rst; d_req_i = dreq; d_addr_i = daddr; d_we_i = dwe; d_be_i = dbe;
    d_wdata_i = dwd; i_req_i = ireq; i_addr_i = iaddr; i_we_i = iwe;
    #1;
    d_in = in_rng(daddr);
    i_in = in_rng(iaddr);
    same = (daddr >> 2) == (iaddr >> 2);
    coll = dreq && dwe && d_in && ireq && !iwe && i_in && same;
    dg = dreq;
    ig = ireq;
`ifdef SRAM_COLLISION_ARB_EN
    if (coll) begin
      if (stall_m == int'(MS)) dg = 0;
      else ig = 0;
    end
`endif
    chk("d_gnt", 32'(d_gnt_o), 32'(dg));
    chk("i_gnt", 32'(i_gnt_o), 32'(ig));
    last_dg = d_gnt_o;
    last_ig = i_gnt_o;

    e_d_rv = 0; e_d_err = 0; e_d_known = 1; e_d_rd = '0;
    e_i_rv = 0; e_i_err = 0; e_i_known = 1; e_i_rd = '0; e_ill = 0;
    if (rst) begin
      cap_v = 0; cap_addr = '0; cap_port = 0; stall_m = 0;
    end else begin
      if (dg) begin
        e_d_rv = 1;
        if (!d_in) e_d_err = 1;
        else if (dwe) e_d_known = 0;
        else if (mem_m.exists(wkey(daddr))) e_d_rd = mem_m[wkey(daddr)];
        else e_d_known = 0;
      end
      if (ig) begin
        e_i_rv = 1;
        if (!i_in || iwe) e_i_err = 1;
        else if (coll && dg) e_i_known = 0;
        else if (mem_m.exists(wkey(iaddr))) e_i_rd = mem_m[wkey(iaddr)];
        else e_i_known = 0;
      end
      e_ill = (dg && !d_in) || (ig && e_i_err);
      if (!cap_v && dg && !d_in) begin
        cap_v = 1; cap_addr = daddr; cap_port = 0;
      end else if (!cap_v && ig && e_i_err) begin
        cap_v = 1; cap_addr = iaddr; cap_port = 1;
      end
      if (dg && d_in && dwe && dbe != 4'h0) begin
        mask = {{8{dbe[3]}}, {8{dbe[2]}}, {8{dbe[1]}}, {8{dbe[0]}}};
        if (mem_m.exists(wkey(daddr))) begin
          old = mem_m[wkey(daddr)];
          mem_m[wkey(daddr)] = (old & ~mask) | (dwd & mask);
        end else if (dbe == 4'hF) begin
          mem_m[wkey(daddr)] = dwd;
        end
      end
      if (ig) stall_m = 0;
      else if (coll) stall_m++;
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, '0, '0, 0, '0, 0);
  endtask
  task automatic dwr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    drive(0, 1, a, 1, be, wd, 0, '0, 0);
  endtask
  task automatic drd(input logic [31:0] a);
    drive(0, 1, a, 0, '0, '0, 0, '0, 0);
  endtask
  task automatic ird(input logic [31:0] a);
    drive(0, 0, '0, 0, '0, '0, 1, a, 0);
  endtask
  task automatic do_reset();
    drive(1, 0, '0, 0, '0, '0, 0, '0, 0);
  endtask

  // Small address pool: 4 words in each bank, the last word, and out-of-range picks.
  function automatic logic [31:0] pool_addr(input int idx);
    if (idx < 32) return BASE + 32'((idx / 4) * 2048 + (idx % 4) * 4);
    return BASE + 32'h3FFC;
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = int'($urandom_range(0, 11));
    logic [31:0] lo = 32'($urandom_range(0, 3));
    if (r < 9) return pool_addr(int'($urandom_range(0, 32))) | lo;
    if (r == 9) return BASE + 32'h4000;
    if (r == 10) return BASE - 32'd4;
    return 32'h8000_C000;
  endfunction

  initial begin
    logic [31:0] a, b;
    int burst;
    rst_i = 1; d_req_i = 0; d_addr_i = '0; d_we_i = 0; d_be_i = '0; d_wdata_i = '0;
    i_req_i = 0; i_addr_i = '0; i_we_i = 0;
    repeat (2) @(negedge clk_i);

    idle();

    // Full-word write then read back on both ports.
    dwr(32'h8000_0804, 4'hF, 32'hDEAD_BEEF);
    drd(32'h8000_0804);
    chk("rb_d_rdata", d_rdata_o, 32'hDEAD_BEEF);
    chk("rb_d_err", 32'(d_err_o), 32'd0);
    ird(32'h8000_0804);
    chk("rb_i_rdata", i_rdata_o, 32'hDEAD_BEEF);

    // Single byte-lane write.
    dwr(32'h8000_0804, 4'b0100, 32'h00AA_0000);
    drd(32'h8000_0804);
    chk("be_rdata", d_rdata_o, 32'hDEAA_BEEF);

    // Out-of-range data read, then a later error that must not overwrite capture.
    drd(32'h8000_C000);
    chk("oor_err", 32'(d_err_o), 32'd1);
    chk("oor_rdata", d_rdata_o, 32'd0);
    chk("oor_illegal", 32'(illegal_memory_o), 32'd1);
    chk("oor_cap_addr", err_addr_o, 32'h8000_C000);
    chk("oor_cap_port", 32'(err_port_o), 32'd0);
    ird(32'h7FFF_FFFC);
    chk("keep_cap_addr", err_addr_o, 32'h8000_C000);

    // Instruction-port write attempt is an error and leaves memory untouched.
    do_reset();
    dwr(32'h8000_0000, 4'hF, 32'h1234_5678);
    drive(0, 0, '0, 0, '0, '0, 1, 32'h8000_0000, 1);
    chk("iwe_err", 32'(i_err_o), 32'd1);
    chk("iwe_cap_port", 32'(err_port_o), 32'd1);
    drd(32'h8000_0000);
    chk("iwe_mem", d_rdata_o, 32'h1234_5678);

    // Same-word write/read collision every cycle.
    ird(32'h8000_0100);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 32'h8000_0100, 1, 4'hF, 32'h1000 + 32'(k), 1, 32'h8000_0100, 0);
`ifdef SRAM_COLLISION_ARB_EN
      chk("coll_i_gnt", 32'(last_ig), (k == 4) ? 32'd1 : 32'd0);
      chk("coll_d_gnt", 32'(last_dg), (k == 4) ? 32'd0 : 32'd1);
      if (k == 4) chk("coll_i_rdata", i_rdata_o, 32'h1003);
`else
      chk("coll_i_gnt", 32'(last_ig), 32'd1);
      chk("coll_d_gnt", 32'(last_dg), 32'd1);
`endif
    end

    // Reset in the cycle a data read is granted drops the response.
    drd(32'h8000_C000);
    drive(1, 1, 32'h8000_0804, 0, '0, '0, 0, '0, 0);
    chk("rst_d_rvalid", 32'(d_rvalid_o), 32'd0);
    chk("rst_err_valid", 32'(err_valid_o), 32'd0);
    chk("rst_illegal", 32'(illegal_memory_o), 32'd0);
    chk("rst_err_addr", err_addr_o, 32'd0);

    // Fill the pool so random reads have known contents.
    for (int p = 0; p <= 32; p++) dwr(pool_addr(p), 4'hF, $urandom);

    burst = 0;
    for (int c = 0; c < 3000; c++) begin
      a = rand_addr();
      b = ($urandom_range(0, 3) == 0) ? a : rand_addr();
      if (burst == 0 && $urandom_range(0, 60) == 0) burst = 7;
      if (burst > 0) begin
        burst--;
        a = pool_addr(5);
        drive(0, 1, a, 1, 4'(($urandom_range(0, 15))), $urandom, 1, a, 0);
      end else if ($urandom_range(0, 250) == 0) begin
        drive(1, $urandom_range(0, 1) == 1, a, 0, '0, '0, 0, '0, 0);
      end else begin
        drive(0, $urandom_range(0, 9) < 7, a, $urandom_range(0, 1) == 1,
              4'($urandom_range(0, 15)), $urandom,
              $urandom_range(0, 9) < 7, b, $urandom_range(0, 15) == 0);
      end
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_banked_ctrl.md
# sram_banked_ctrl

Parametrised dual-port controller for the on-chip SRAM region, sitting between the core's data/instruction OBI ports and a bank array of sky130 1rw1r 32x512 macros. Generalises the fixed 8-bank wrapper:
- configurable bank count and base address;
- out-of-range and illegal-write detection, reported through an OBI error response and a sticky error-capture register;
- optional arbitration of same-word data-write / instruction-read collisions with a starvation guard.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of bank 0 word 0; must be aligned to NUM_BANKS*2 kB rounded up to a power of two
- NUM_BANKS, 8, number of 2 kB banks (1..16)
- BANK_AW, 9, word-address width per bank (fixed by macro: 512 words)
- MAX_STALL, 4, consecutive collision stalls tolerated on the instruction port before it takes priority (1..15)

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- d_req_i  in  1  data request
- d_gnt_o  out  1  data grant
- d_addr_i  in  32  data byte address
- d_we_i  in  1  write enable
- d_be_i  in  4  byte enables
- d_wdata_i  in  32  write data
- d_rvalid_o  out  1  data response valid
- d_rdata_o  out  32  data read data
- d_err_o  out  1  data error response, valid with d_rvalid_o
- i_req_i  in  1  instruction request
- i_gnt_o  out  1  instruction grant
- i_addr_i  in  32  instruction byte address
- i_we_i  in  1  instruction write attempt (always illegal)
- i_rvalid_o  out  1  instruction response valid
- i_rdata_o  out  32  instruction read data
- i_err_o  out  1  instruction error response
- illegal_memory_o  out  1  one-cycle pulse, coincident with any error response
- err_valid_o  out  1  sticky: an error occurred since reset
- err_addr_o  out  32  address of the first erroring access since reset
- err_port_o  out  1  0 = data port, 1 = instruction port, for the captured error

## Operation
- Decode: in_range = BASE_ADDR <= addr < BASE_ADDR + NUM_BANKS*2048. Bank = addr[BANK_AW+2 +: log2(NUM_BANKS)], word = addr[BANK_AW+1:2]. addr[1:0] are ignored.
- Legal data access: the selected bank's rw port is enabled (csb0 low); web0 = ~d_we_i; wmask0 = d_be_i. A write with be = 0 is a granted no-op.
- Legal instruction read: the selected bank's r port is enabled.
- Error access (out of range, or i_we_i = 1):
  - granted; no bank is enabled;
  - response carries err = 1 and rdata = 0;
  - illegal_memory_o pulses.
- Error capture: on the first error after reset, err_valid_o is set and err_addr_o/err_port_o are loaded. Later errors do not overwrite them. If both ports error in the same cycle, the data port is captured.
- Read-data mux: selected by the registered per-port bank one-hot. rdata is 0 whenever rvalid is 0 or err is 1.
- Collision: same cycle, d write and i read, both legal, same bank and word.
  - Normal case: the data port wins; i_gnt_o = 0; the stall counter increments.
  - When the counter equals MAX_STALL: the instruction port wins; d_gnt_o = 0; the counter clears.
  - Any granted instruction request clears the counter.

## Timing
- Grants are combinational, in the same cycle as the request. Full throughput: one access per port per cycle.
- rvalid/err/rdata follow exactly one cycle after a granted request. There is no backpressure.
- Reset values: all rvalid/err/rdata outputs, illegal_memory_o, err_valid_o, err_addr_o, err_port_o and the stall counter are 0.
- Reset asserted while a request is granted: the response is dropped (rvalid 0 next cycle). Bank enables are forced off during reset.
- Simultaneous d read and i read of the same word is not a collision; both are granted.

## Configuration
- SRAM_COLLISION_ARB_EN defined: collision arbitration and the stall counter are present, as described above.
- SRAM_COLLISION_ARB_EN undefined: both ports are always granted and the counter is absent. The instruction rdata of a colliding read is undefined; err stays 0.

## Structure
- Package sram_pkg holds:
  - SRAM_BANK_BYTES (2048) and SRAM_MACRO_AW (9);
  - typedef obi_err_src_e {ERR_DPORT, ERR_IPORT};
  - function sram_in_range.
- Sub-module sram_bank wraps one sky130_sram_2kbyte_1rw1r_32x512_8 (DELAY 0) with active-high enables. It is generated NUM_BANKS times.

## Test plan
- Write 0xDEADBEEF, be 4'b1111, to 0x8000_0804; read it back on the d-port and then the i-port → rvalid after 1 cycle, rdata 0xDEADBEEF, err 0.
- Write be 4'b0100 with data 0x00AA0000 over 0xDEADBEEF at the same word → readback 0xDEAABEEF.
- d read of 0x8000_C000 (NUM_BANKS = 8) → gnt same cycle; next cycle err 1, rdata 0, illegal_memory_o pulse; err_addr_o 0x8000_C000, err_port_o 0. A later error leaves the capture unchanged.
- i-port request with i_we_i = 1 to 0x8000_0000 → i_err_o 1, err_port_o 1, memory unchanged.
- SRAM_COLLISION_ARB_EN, MAX_STALL 4: d writes and i reads 0x8000_0100 every cycle → i_gnt_o low for 4 cycles, then on the 5th cycle i_gnt_o 1 and d_gnt_o 0; the i response returns the last written data.
- Assert rst_i in the same cycle a d read is granted → d_rvalid_o 0 on the next cycle; all status outputs 0.
